// File: rtl/wb_trace_display.sv
// wb_trace_display
// Captures register-writeback events into a small FIFO and shows them on the
// 4-digit HEX display. A debounced step key walks through the captured entries.
// When nothing is being browsed, the display shows the most recent writeback.
//
// Ports
//   I_CLOCK            pipeline clock
//   I_RESET_N          asynchronous active-low reset
//   I_LOCK             pipeline lock; captures are ignored while low
//   I_WriteBackEnable  writeback valid this cycle
//   I_WriteBackRegIdx  destination register index
//   I_WriteBackData    value written (REG_WIDTH bits)
//   I_KEY_N            raw step key, active-low, asynchronous
//   O_Digits           four nibbles for the SevenSeg decoders (HEX3..HEX0)
//   O_RegIdx           register index of the displayed value
//   O_View             1 = browsing the FIFO, 0 = live view
//   O_Count            number of entries held
//   O_Empty / O_Full   FIFO status
//   O_Overflow         sticky: an event was dropped because the FIFO was full
module wb_trace_display #(
    parameter int REG_WIDTH       = 16,
    parameter int DEPTH           = 16,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                       I_CLOCK,
    input  logic                       I_RESET_N,
    input  logic                       I_LOCK,
    input  logic                       I_WriteBackEnable,
    input  logic [3:0]                 I_WriteBackRegIdx,
    input  logic [REG_WIDTH-1:0]       I_WriteBackData,
    input  logic                       I_KEY_N,
    output logic [15:0]                O_Digits,
    output logic [3:0]                 O_RegIdx,
    output logic                       O_View,
    output logic [$clog2(DEPTH):0]     O_Count,
    output logic                       O_Empty,
    output logic                       O_Full,
    output logic                       O_Overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EW  = REG_WIDTH + 4;

    typedef enum logic [0:0] {
        ST_LIVE = 1'b0,
        ST_VIEW = 1'b1
    } state_t;

    // Key path
    logic           key_meta_r;
    logic           key_sync_r;
    logic           key_deb_r;
    logic [DBW-1:0] deb_cnt_r;
    logic           step_r;

    // FIFO and live capture
    logic [EW-1:0]          mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   overflow_r;
    logic [3:0]             last_idx_r;
    logic [REG_WIDTH-1:0]   last_data_r;
    state_t                 state_r;

    logic                   push_s;
    logic                   pop_s;
    logic                   accept_s;
    logic                   empty_s;
    logic                   full_s;
    logic [EW-1:0]          head_s;
    logic [3:0]             head_idx_s;
    logic [REG_WIDTH-1:0]   head_data_s;
    logic [15:0]            head_disp_s;
    logic [15:0]            live_disp_s;

    // Synchroniser, stability counter and single step pulse on debounced press
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
            key_deb_r  <= 1'b1;
            deb_cnt_r  <= {DBW{1'b0}};
            step_r     <= 1'b0;
        end else begin
            key_meta_r <= I_KEY_N;
            key_sync_r <= key_meta_r;
            step_r     <= 1'b0;
            if (key_sync_r == key_deb_r) begin
                deb_cnt_r <= {DBW{1'b0}};
            end else if (deb_cnt_r == DBW'(DEBOUNCE_CYCLES - 1)) begin
                // Sample DEBOUNCE_CYCLES in a row differs: accept the new level.
                key_deb_r <= key_sync_r;
                deb_cnt_r <= {DBW{1'b0}};
                step_r    <= ~key_sync_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DBW'(1);
            end
        end
    end

    // FIFO control decode
    always_comb begin
        push_s   = I_LOCK & I_WriteBackEnable;
        empty_s  = (count_r == CW'(0));
        full_s   = (count_r == CW'(DEPTH));
        pop_s    = step_r & (state_r == ST_VIEW) & ~empty_s;
        // A pop in the same cycle frees a slot, so a push on a full FIFO still fits.
        accept_s = push_s & (~full_s | pop_s);
    end

    // FIFO storage write (data only, no reset needed: count gates visibility)
    always_ff @(posedge I_CLOCK) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= {I_WriteBackRegIdx, I_WriteBackData};
        end
    end

    // Pointers, count, overflow flag, live register and view FSM
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            last_idx_r  <= 4'd0;
            last_data_r <= {REG_WIDTH{1'b0}};
            state_r     <= ST_LIVE;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && !accept_s) begin
                overflow_r <= 1'b1;
            end
            // The live view tracks every push, including dropped ones.
            if (push_s) begin
                last_idx_r  <= I_WriteBackRegIdx;
                last_data_r <= I_WriteBackData;
            end
            case (state_r)
                ST_LIVE: begin
                    if (step_r && !empty_s) begin
                        state_r <= ST_VIEW;
                    end
                end
                ST_VIEW: begin
                    if (pop_s && (count_r == CW'(1)) && !accept_s) begin
                        state_r <= ST_LIVE;
                    end
                end
                default: state_r <= ST_LIVE;
            endcase
        end
    end

    // Head of FIFO unpacked into index and data
    always_comb begin
        head_s      = mem_r[rd_ptr_r];
        head_idx_s  = head_s[EW-1:REG_WIDTH];
        head_data_s = head_s[REG_WIDTH-1:0];
    end

    // Fit writeback data to the 16-bit display: truncate wide, zero-extend narrow.
    generate
        if (REG_WIDTH >= 16) begin : g_trunc
            assign head_disp_s = head_data_s[15:0];
            assign live_disp_s = last_data_r[15:0];
        end else begin : g_ext
            assign head_disp_s = {{(16 - REG_WIDTH){1'b0}}, head_data_s};
            assign live_disp_s = {{(16 - REG_WIDTH){1'b0}}, last_data_r};
        end
    endgenerate

    // Output selection between live register and FIFO head
    always_comb begin
        if (state_r == ST_VIEW) begin
            O_Digits = head_disp_s;
            O_RegIdx = head_idx_s;
        end else begin
            O_Digits = live_disp_s;
            O_RegIdx = last_idx_r;
        end
        O_View     = (state_r == ST_VIEW);
        O_Count    = count_r;
        O_Empty    = empty_s;
        O_Full     = full_s;
        O_Overflow = overflow_r;
    end

endmodule

// File: tb/tb_wb_trace_display.sv
module tb_wb_trace_display;

    localparam int DB = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  idx = 4'd0;
    logic [15:0] data = 16'd0;
    logic        key_n = 1'b1;
    logic [15:0] digits;
    logic [3:0]  regidx;
    logic        view;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        ovf;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    wb_trace_display #(
        .REG_WIDTH(16),
        .DEPTH(16),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .I_CLOCK(clk),
        .I_RESET_N(rst_n),
        .I_LOCK(lock),
        .I_WriteBackEnable(we),
        .I_WriteBackRegIdx(idx),
        .I_WriteBackData(data),
        .I_KEY_N(key_n),
        .O_Digits(digits),
        .O_RegIdx(regidx),
        .O_View(view),
        .O_Count(count),
        .O_Empty(empty),
        .O_Full(full),
        .O_Overflow(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.step_r) pulse_cnt++;
    end

    typedef struct {
        logic        rst;
        logic        lock;
        logic        we;
        logic [3:0]  idx;
        logic [15:0] data;
        logic [4:0]  e_count;
        logic [15:0] e_digits;
        logic [3:0]  e_idx;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [4:0] c, input logic [15:0] d,
                           input logic [3:0] ri, input logic v, input logic e,
                           input logic f, input logic o);
        chk({nm, ".count"}, 32'(count), 32'(c));
        chk({nm, ".digits"}, 32'(digits), 32'(d));
        chk({nm, ".regidx"}, 32'(regidx), 32'(ri));
        chk({nm, ".view"}, 32'(view), 32'(v));
        chk({nm, ".empty"}, 32'(empty), 32'(e));
        chk({nm, ".full"}, 32'(full), 32'(f));
        chk({nm, ".ovf"}, 32'(ovf), 32'(o));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        we    = 1'b0;
        key_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] pi, input logic [15:0] pd);
        lock = 1'b1;
        we   = 1'b1;
        idx  = pi;
        data = pd;
        @(negedge clk);
        we   = 1'b0;
    endtask

    // Press the key, optionally push in the step cycle, then release and settle.
    task automatic press(input logic do_push, input logic [3:0] pi, input logic [15:0] pd);
        logic seen;
        seen  = 1'b0;
        key_n = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dut.step_r) begin
                seen = 1'b1;
                break;
            end
        end
        chk("press_pulse_seen", 32'(seen), 32'd1);
        if (seen && do_push) begin
            lock = 1'b1;
            we   = 1'b1;
            idx  = pi;
            data = pd;
        end
        @(negedge clk);
        we    = 1'b0;
        key_n = 1'b1;
        repeat (DB + 6) @(negedge clk);
    endtask

    initial begin
        int lat;
        int p0;

        // Tests 1 and 2 as a table: single push, lock/enable gating, fill, overflow.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 4'd3, 16'h1234, 5'd1, 16'h1234, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 4'd5, 16'h5555, 5'd1, 16'h1234, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd6, 16'h6666, 5'd1, 16'h1234, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 4'd0, 16'h0000, 5'd1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i < 16; i++) begin
            vecs[3 + i] = '{1'b0, 1'b1, 1'b1, 4'(i), 16'(i), 5'(i + 1), 16'(i), 4'(i),
                            1'b0, (i == 15), 1'b0};
        end
        vecs[19] = '{1'b0, 1'b1, 1'b1, 4'hE, 16'hBEEF, 5'd16, 16'hBEEF, 4'hE, 1'b0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                chk_all($sformatf("reset%0d", i), 5'd0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            lock = vecs[i].lock;
            we   = vecs[i].we;
            idx  = vecs[i].idx;
            data = vecs[i].data;
            @(negedge clk);
            we   = 1'b0;
            lock = 1'b1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_digits, vecs[i].e_idx,
                    1'b0, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf);
        end

        // Test 3: browse all 16 entries, the 17th press returns to live.
        for (int k = 1; k <= 17; k++) begin
            press(1'b0, 4'd0, 16'd0);
            if (k <= 16) begin
                chk_all($sformatf("browse%0d", k), 5'(17 - k), 16'(k - 1), 4'(k - 1),
                        1'b1, 1'b0, (k == 1), 1'b1);
            end else begin
                chk_all("browse_end", 5'd0, 16'hBEEF, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1);
            end
        end

        // Test 4: bouncing key gives one pulse, 66 cycles after the final edge.
        do_reset();
        p0 = pulse_cnt;
        for (int t = 0; t < 20; t++) begin
            key_n = ~key_n;
            repeat (10) @(negedge clk);
        end
        chk("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        key_n = 1'b0;
        lat = -1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (dut.step_r) begin
                lat = c;
                break;
            end
        end
        chk("pulse_latency", 32'(lat), 32'd66);
        repeat (100) @(negedge clk);
        chk("hold_one_pulse", 32'(pulse_cnt - p0), 32'd1);
        chk("empty_step_stays_live", 32'(view), 32'd0);
        key_n = 1'b1;
        repeat (DB + 6) @(negedge clk);
        chk("release_no_pulse", 32'(pulse_cnt - p0), 32'd1);

        // Test 5: full FIFO in view, push and step in the same cycle.
        for (int i = 0; i < 16; i++) push(4'(i), 16'h0100 + 16'(i));
        chk_all("fill2", 5'd16, 16'h010F, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 4'd0, 16'd0);
        chk_all("view_full", 5'd16, 16'h0100, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        press(1'b1, 4'hA, 16'hAAAA);
        chk_all("push_pop_full", 5'd16, 16'h0101, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 15; j++) begin
            press(1'b0, 4'd0, 16'd0);
            chk($sformatf("tail_walk%0d", j), 32'(digits),
                (j < 15) ? 32'(16'h0101 + 16'(j)) : 32'h0000AAAA);
        end
        chk_all("tail_is_aaaa", 5'd1, 16'hAAAA, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Test 6: asynchronous reset in view with five entries.
        for (int i = 0; i < 4; i++) push(4'(i + 1), 16'h0C00 + 16'(i));
        chk_all("view_count5", 5'd5, 16'hAAAA, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 5'd0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all("after_release", 5'd0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
